prng_sampler: RTL and testbench
===============================

# prng_sampler

Multi-channel, bounded-range pseudo-random sample generator for the RRT sampling front end. It runs one xorshift64 generator per channel (shifts 13/7/17) and maps each channel's high 32 bits into [0, bound) with a multiply-shift. All channels together produce one coordinate tuple per accepted transfer over a valid/ready handshake. It supports synchronous reseeding, zero-seed protection, stall without state advance, and an accepted-sample counter.

## Interface
- CHANNELS, default 2: number of independent generators, 1..8 (e.g. x, y).
- OUT_W, default 16: sample width per channel, 1..32.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- seed  in  64*CHANNELS  per-channel seed; channel i at [64*i +: 64]. Sampled during reset and on reseed. Must be stable while rst_n is low.
- reseed  in  1  synchronous reload of all states from seed.
- bound  in  OUT_W*CHANNELS  per-channel exclusive upper bound; channel i at [OUT_W*i +: OUT_W].
- out_valid  out  1  out_data holds an unconsumed sample tuple.
- out_ready  in  1  consumer accepts out_data when high with out_valid.
- out_data  out  OUT_W*CHANNELS  sample tuple; channel i at [OUT_W*i +: OUT_W].
- count  out  32  number of accepted transfers; wraps modulo 2^32.

## Operation
- Sanitised seed: san(seed_i) = seed_i when non-zero. When zero, it is 64'h9E37_79B9_7F4A_7C15 + i. The all-zero state is therefore unreachable.
- Step function: xs(s) = t2 ^ (t2 << 17), where t2 = t1 ^ (t1 >> 7) and t1 = s ^ (s << 13). All shifts are logical, 64-bit, and truncating.
- Map: map_i(s) = (s[63:32] * bound_i) >> 32.
  - The product is 32+OUT_W bits wide; the result keeps the low OUT_W bits of the shifted product.
  - The result is always < bound_i.
  - bound_i = 0 gives 0.
- Load condition: load = !reseed && (!out_valid || out_ready).
  - On load, every channel updates in lockstep: state_i <= xs(state_i), out_data_i <= map_i(xs(state_i)), out_valid <= 1.
- Without load and without reseed: states, out_data and out_valid hold.
- Reseed (priority over load): state_i <= san(seed_i) and out_valid <= 0. out_data holds its old value.
- count increments on every edge where out_valid && out_ready. This includes a reseed edge, because that sample was consumed.
- bound is sampled at the load edge only. Changing bound never alters an already-presented sample.

## Timing
- Reset values:
  - state_i = san(seed_i)
  - out_valid = 0
  - out_data = 0
  - count = 0
- First rising edge after rst_n deasserts: a load occurs, so out_valid = 1 from then on. The first sample is computed from xs(san(seed)).
- Throughput: one tuple per cycle while out_ready is held high. There are no bubbles.
- Latency from a load edge to the sample appearing on out_data: 0 cycles (registered output).
- Stall: while out_valid && !out_ready, out_data and out_valid must be bit-stable and generator states frozen. No sample is skipped or duplicated.
- Reseed: out_valid is low for exactly the one cycle after the reseed edge. The next edge loads xs(san(new seed)), provided reseed is deasserted.
- Reseed held high: out_valid stays 0 and states are reloaded each edge.
- Reset asserted mid-operation: all registers go asynchronously to their reset values. Sequence restarts from the seed.
- count wraps from 32'hFFFF_FFFF to 0.

## Test plan
- Seed sanity:
  - Stimulus: CHANNELS=2, OUT_W=16, seed0=1, bound0=16'hFFFF, out_ready=1; release reset.
  - Response: internal state0 = 64'h0000_0000_4082_2041 after the first edge, out_data ch0 = 0, out_valid = 1 one edge after release.
  - Then compare 1000 tuples against a software xorshift64 + multiply-shift model.
- Zero seed and zero bound:
  - Stimulus: seed1=0.
  - Response: ch1 sequence equals the model seeded with 64'h9E37_79B9_7F4A_7C16; state never 0 over 10^4 steps.
  - Stimulus: bound1=0.
  - Response: ch1 output 0 every cycle.
- Range: random bounds 1..16'hFFFF changed every cycle; every sample < the bound in effect at its load edge.
- Backpressure:
  - Stimulus: random out_ready at 30% duty.
  - Response: out_data stable while stalled; accepted stream identical to the full-rate stream; count equals the number of handshakes.
- Reseed mid-stream:
  - Stimulus: pulse reseed for one cycle with out_valid=1, out_ready=1 and new seeds.
  - Response: count increments on that edge; out_valid=0 for one cycle; next tuple equals the model from the new seed.
  - Stimulus: hold reseed for 5 cycles.
  - Response: out_valid stays 0 throughout.
- Reset mid-operation and wrap:
  - Stimulus: assert rst_n low between clock edges after 50 samples.
  - Response: outputs go to 0 immediately; after release the sequence repeats from sample 1.
  - Stimulus: force count to 32'hFFFF_FFFF, then one handshake.
  - Response: count = 0.

Source files
------------

// File: rtl/prng_sampler.sv
// Multi-channel xorshift64 sample generator with multiply-shift range mapping,
// valid/ready output, synchronous reseed and an accepted-transfer counter.
module prng_sampler #(
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [64*CHANNELS-1:0]    seed,
    input  logic                      reseed,
    input  logic [OUT_W*CHANNELS-1:0] bound,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W*CHANNELS-1:0] out_data,
    output logic [31:0]               count
);

    localparam logic [63:0] ZERO_SEED_BASE = 64'h9E37_79B9_7F4A_7C15;

    logic [64*CHANNELS-1:0]    state;
    logic [64*CHANNELS-1:0]    san_state;
    logic [64*CHANNELS-1:0]    next_state;
    logic [OUT_W*CHANNELS-1:0] next_data;
    logic                      load;
    logic                      accept;

    function automatic logic [63:0] xs(input logic [63:0] s);
        logic [63:0] t1;
        logic [63:0] t2;
        t1 = s ^ (s << 13);
        t2 = t1 ^ (t1 >> 7);
        return t2 ^ (t2 << 17);
    endfunction

    // High 32 bits times bound, keep bits [32 +: OUT_W]; result is always < b.
    function automatic logic [OUT_W-1:0] map_sample(input logic [63:0] s,
                                                    input logic [OUT_W-1:0] b);
        logic [32+OUT_W-1:0] prod;
        prod = {{OUT_W{1'b0}}, s[63:32]} * {32'd0, b};
        return prod[32 +: OUT_W];
    endfunction

    always_comb begin
        logic [63:0] ns;
        san_state  = '0;
        next_state = '0;
        next_data  = '0;
        ns         = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (seed[64*i +: 64] == 64'd0)
                san_state[64*i +: 64] = ZERO_SEED_BASE + 64'(i);
            else
                san_state[64*i +: 64] = seed[64*i +: 64];
            ns = xs(state[64*i +: 64]);
            next_state[64*i +: 64]      = ns;
            next_data[OUT_W*i +: OUT_W] = map_sample(ns, bound[OUT_W*i +: OUT_W]);
        end
    end

    assign load   = !reseed && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;

    // Reseed beats load; the counter still sees a sample consumed on a reseed edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= san_state;
            out_valid <= 1'b0;
            out_data  <= '0;
            count     <= 32'd0;
        end else begin
            if (accept)
                count <= count + 32'd1;
            if (reseed) begin
                state     <= san_state;
                out_valid <= 1'b0;
            end else if (load) begin
                state     <= next_state;
                out_data  <= next_data;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prng_sampler.sv
// Bench for prng_sampler: reset vectors from a table, then randomized traffic
// against a cycle model and an independently iterated xorshift64 reference stream.
module tb_prng_sampler;

    localparam int CH    = 2;
    localparam int OUT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [64*CH-1:0]   seed;
    logic               reseed;
    logic [OUT_W*CH-1:0] bound;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W*CH-1:0] out_data;
    logic [31:0]        count;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]      m_state [CH];
    logic [OUT_W-1:0] m_data  [CH];
    logic [OUT_W-1:0] m_bound [CH];
    logic             m_valid;
    logic [31:0]      m_count;

    logic [OUT_W*CH-1:0] acc [$];

    typedef struct {
        logic [63:0]      s0;
        logic [63:0]      s1;
        logic [OUT_W-1:0] b0;
        logic [OUT_W-1:0] b1;
        logic [63:0]      exp_state0;
        logic [OUT_W-1:0] exp_d0;
        logic [OUT_W-1:0] exp_d1;
    } vec_t;

    vec_t vecs [4];

    prng_sampler #(.CHANNELS(CH), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (seed),
        .reseed    (reseed),
        .bound     (bound),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_san(input logic [63:0] s, input int i);
        return (s == 64'd0) ? 64'h9E37_79B9_7F4A_7C15 + 64'(i) : s;
    endfunction

    function automatic logic [63:0] ref_xs(input logic [63:0] s);
        logic [63:0] v;
        v = s;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    // Scaled fraction: floor(hi32 * b / 2^32) in plain 64-bit arithmetic.
    function automatic logic [OUT_W-1:0] ref_map(input logic [63:0] s, input logic [OUT_W-1:0] b);
        logic [63:0] p;
        p = (s >> 32) * {48'd0, b};
        return OUT_W'(p >> 32);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input logic [63:0] act);
        vectors++;
        if (!cond) begin
            miscompares++;
            $display("[TB] FAIL %s: offending value %h", name, act);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_state[i] = ref_san(seed[64*i +: 64], i);
            m_data[i]  = '0;
            m_bound[i] = '0;
        end
        m_valid = 1'b0;
        m_count = 32'd0;
    endtask

    task automatic model_edge();
        bit take;
        take = m_valid && out_ready;
        if (take)
            m_count = m_count + 32'd1;
        if (reseed) begin
            for (int i = 0; i < CH; i++)
                m_state[i] = ref_san(seed[64*i +: 64], i);
            m_valid = 1'b0;
        end else if (!m_valid || out_ready) begin
            for (int i = 0; i < CH; i++) begin
                m_state[i] = ref_xs(m_state[i]);
                m_bound[i] = bound[OUT_W*i +: OUT_W];
                m_data[i]  = ref_map(m_state[i], m_bound[i]);
            end
            m_valid = 1'b1;
        end
    endtask

    task automatic check_output();
        logic [OUT_W-1:0] d;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("count", 64'(count), 64'(m_count));
        for (int i = 0; i < CH; i++) begin
            d = out_data[OUT_W*i +: OUT_W];
            check($sformatf("out_data ch%0d", i), 64'(d), 64'(m_data[i]));
            if (m_valid)
                check_true($sformatf("range ch%0d", i),
                           (m_bound[i] == 0) ? (d == 0) : (d < m_bound[i]), 64'(d));
        end
    endtask

    task automatic tick();
        if (out_valid && out_ready)
            acc.push_back(out_data);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        seed      = {v.s1, v.s0};
        bound     = {v.b1, v.b0};
        out_ready = 1'b1;
        reseed    = 1'b0;
        do_reset();
        check_output();
        tick();
        check_output();
        check("first d0", 64'(out_data[0 +: OUT_W]), 64'(v.exp_d0));
        check("first d1", 64'(out_data[OUT_W +: OUT_W]), 64'(v.exp_d1));
        check("first state0", dut.state[63:0], v.exp_state0);
    endtask

    initial begin
        logic [63:0] r0, r1, ns0, ns1;
        logic [OUT_W-1:0] fb0, fb1;
        logic [OUT_W*CH-1:0] first_tuple;
        int pass_cnt;

        rst_n     = 1'b0;
        reseed    = 1'b0;
        out_ready = 1'b0;
        seed      = '0;
        bound     = '0;

        vecs[0] = '{64'd1, 64'h1234_5678_9ABC_DEF0, 16'hFFFF, 16'hFFFF,
                    64'h0000_0000_4082_2041, 16'h0000, 16'h0};
        vecs[0].exp_d1 = ref_map(ref_xs(64'h1234_5678_9ABC_DEF0), 16'hFFFF);
        vecs[1] = '{64'd0, 64'd0, 16'd1000, 16'd0, 64'd0, 16'd0, 16'd0};
        vecs[1].exp_state0 = ref_xs(64'h9E37_79B9_7F4A_7C15);
        vecs[1].exp_d0     = ref_map(ref_xs(64'h9E37_79B9_7F4A_7C15), 16'd1000);
        vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 64'd1, 16'd1, 16'd7, 64'd0, 16'd0, 16'd0};
        vecs[2].exp_state0 = ref_xs(64'hDEAD_BEEF_CAFE_F00D);
        vecs[2].exp_d1     = ref_map(ref_xs(64'd1), 16'd7);
        vecs[3].s0 = {$urandom, $urandom};
        vecs[3].s1 = {$urandom, $urandom};
        vecs[3].b0 = 16'($urandom_range(1, 16'hFFFF));
        vecs[3].b1 = 16'($urandom_range(1, 16'hFFFF));
        vecs[3].exp_state0 = ref_xs(ref_san(vecs[3].s0, 0));
        vecs[3].exp_d0     = ref_map(ref_xs(ref_san(vecs[3].s0, 0)), vecs[3].b0);
        vecs[3].exp_d1     = ref_map(ref_xs(ref_san(vecs[3].s1, 1)), vecs[3].b1);

        for (int k = 0; k < 4; k++)
            apply_stimulus(vecs[k]);

        // Full-rate stream from seed0=1, seed1=0 against independently iterated references.
        seed  = {64'd0, 64'd1};
        bound = {16'hFFFF, 16'hFFFF};
        do_reset();
        r0 = 64'd1;
        r1 = 64'h9E37_79B9_7F4A_7C16;
        for (int k = 0; k < 1000; k++) begin
            tick();
            r0 = ref_xs(r0);
            r1 = ref_xs(r1);
            check_output();
            check("stream ch0", 64'(out_data[0 +: OUT_W]), 64'(ref_map(r0, 16'hFFFF)));
            check("stream ch1", 64'(out_data[OUT_W +: OUT_W]), 64'(ref_map(r1, 16'hFFFF)));
        end

        bound = {16'h0000, 16'hFFFF};
        for (int k = 0; k < 10000; k++) begin
            tick();
            check("zero bound ch1", 64'(out_data[OUT_W +: OUT_W]), 64'd0);
            check_true("state1 nonzero", dut.state[127:64] != 64'd0, dut.state[127:64]);
        end

        for (int k = 0; k < 500; k++) begin
            bound = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF))};
            tick();
            check_output();
        end

        // Backpressure: accepted tuples must equal the full-rate sequence.
        seed  = {$urandom, $urandom, $urandom, $urandom};
        fb0   = 16'($urandom_range(1, 16'hFFFF));
        fb1   = 16'($urandom_range(1, 16'hFFFF));
        bound = {fb1, fb0};
        do_reset();
        acc.delete();
        for (int k = 0; k < 2000; k++) begin
            out_ready = ($urandom_range(0, 99) < 30);
            tick();
            check_output();
        end
        check("handshake count", 64'(count), 64'(acc.size()));
        r0 = ref_san(seed[63:0], 0);
        r1 = ref_san(seed[127:64], 1);
        for (int k = 0; k < acc.size(); k++) begin
            r0 = ref_xs(r0);
            r1 = ref_xs(r1);
            check("accepted ch0", 64'(acc[k][0 +: OUT_W]), 64'(ref_map(r0, fb0)));
            check("accepted ch1", 64'(acc[k][OUT_W +: OUT_W]), 64'(ref_map(r1, fb1)));
        end

        // Reseed pulse while a sample is being consumed.
        out_ready = 1'b1;
        tick();
        check("pre-reseed valid", 64'(out_valid), 64'd1);
        pass_cnt = int'(count);
        seed   = {64'h0F0F_1234_0000_0001, 64'hA5A5_5A5A_0000_0077};
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        check_output();
        check("reseed count", 64'(count), 64'(pass_cnt + 1));
        check("reseed valid low", 64'(out_valid), 64'd0);
        tick();
        check_output();
        ns0 = ref_xs(64'hA5A5_5A5A_0000_0077);
        ns1 = ref_xs(64'h0F0F_1234_0000_0001);
        check("reseed ch0", 64'(out_data[0 +: OUT_W]), 64'(ref_map(ns0, fb0)));
        check("reseed ch1", 64'(out_data[OUT_W +: OUT_W]), 64'(ref_map(ns1, fb1)));

        seed   = {64'd0, 64'd0};
        reseed = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("reseed held valid", 64'(out_valid), 64'd0);
            check_output();
        end
        reseed = 1'b0;
        tick();
        check_output();
        check("held reseed ch0", 64'(out_data[0 +: OUT_W]),
              64'(ref_map(ref_xs(64'h9E37_79B9_7F4A_7C15), fb0)));

        // Asynchronous reset mid-stream, then the sequence restarts.
        seed  = {64'h7777_0000_1111_2222, 64'h0000_0000_0000_BEEF};
        bound = {16'd5000, 16'd300};
        do_reset();
        first_tuple = {ref_map(ref_xs(64'h7777_0000_1111_2222), 16'd5000),
                       ref_map(ref_xs(64'h0000_0000_0000_BEEF), 16'd300)};
        for (int k = 0; k < 50; k++) begin
            tick();
            check_output();
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset valid", 64'(out_valid), 64'd0);
        check("async reset data", 64'(out_data), 64'd0);
        check("async reset count", 64'(count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_output();
        check("restart tuple", 64'(out_data), 64'(first_tuple));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
